// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads instrMem, hands words to decode.
// Ports: clk/rst, iaddr/idata (memory), redirect_valid/redirect_pc, halt,
// out_valid/out_ready/out_instr/out_pc (decode handshake), halted, fault, fault_pc.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched/perf_stalled counters.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalled
`endif
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        ov_n;
  logic [31:0] oi_n, op_n;
  logic        f_n;
  logic [31:0] fpc_n;
  logic        bad_rd;
  logic        slot_free;

  assign iaddr     = pc;
  assign halted    = (state == HALTED);
  assign bad_rd    = (redirect_pc[1:0] != 2'b00) ||
                     (redirect_pc > LAST_PC);
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      fault     <= 1'b0;
      fault_pc  <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      out_valid <= ov_n;
      out_instr <= oi_n;
      out_pc    <= op_n;
      fault     <= f_n;
      fault_pc  <= fpc_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    // Default: the held entry drains when decode takes it.
    ov_n    = out_valid && !out_ready;
    oi_n    = out_instr;
    op_n    = out_pc;
    f_n     = fault;
    fpc_n   = fault_pc;
    unique case (state)
      FETCH: begin
        if (redirect_valid) begin
          ov_n = 1'b0;
          if (bad_rd) begin
            state_n = FAULT;
            f_n     = 1'b1;
            fpc_n   = redirect_pc;
          end else begin
            pc_n = redirect_pc;
            if (halt) state_n = HALTED;
          end
        end else if (halt) begin
          state_n = HALTED;
        end else if (pc > LAST_PC) begin
          // Sequential run fell off the end of memory.
          state_n = FAULT;
          f_n     = 1'b1;
          fpc_n   = pc;
        end else if (slot_free) begin
          oi_n = idata;
          op_n = pc;
          ov_n = 1'b1;
          pc_n = pc + 32'd4;
        end
      end
      HALTED: begin
        if (redirect_valid && bad_rd) begin
          ov_n    = 1'b0;
          state_n = FAULT;
          f_n     = 1'b1;
          fpc_n   = redirect_pc;
        end else begin
          if (redirect_valid) begin
            ov_n = 1'b0;
            pc_n = redirect_pc;
          end
          if (!halt) state_n = FETCH;
        end
      end
      FAULT: begin
      end
      default: begin
        state_n = FETCH;
      end
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stalled <= '0;
    end else begin
      if (out_valid && out_ready)
        perf_fetched <= perf_fetched + 32'd1;
      if (state == FETCH && out_valid && !out_ready)
        perf_stalled <= perf_stalled + 32'd1;
    end
  end
`endif

endmodule
